nor_tester_seq: RTL and testbench
=================================

NOR_TESTER_SEQ -- requirements
Module: nor_tester_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles the drive vector is held before y_in is sampled; legal range 1..255.
REQ-002 SHALL have parameter ERR_W, default 3: width of the error counter; legal range 2..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request one exhaustive test run; accepted only in IDLE.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of a run in progress.
REQ-007 SHALL have port y_in, input, 1: output of the 2-input NOR gate under test.
REQ-008 SHALL have ports a_out and b_out, output, 1 each: registered drive to the gate's a and b inputs.
REQ-009 SHALL have port busy, output, 1: high while in WAIT or SAMPLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking run completion.
REQ-011 SHALL have port pass, output, 1: high when the last completed run had zero mismatches.
REQ-012 SHALL have port err_cnt, output, ERR_W: saturating mismatch count for the last or current run.
REQ-013 SHALL have port fail_vec, output, 4: bit i set when vector i, where i = {a,b}, mismatched.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, SAMPLE and DONE, plus a 2-bit vector index vec and a settle counter.
REQ-015 SHALL drive a_out = vec[1] and b_out = vec[0] in WAIT and SAMPLE, and a_out = b_out = 0 in IDLE and DONE.
REQ-016 IDLE: start=1 at an edge SHALL move to WAIT with vec=0 and settle count=0, and SHALL clear err_cnt, fail_vec and pass.
REQ-017 WAIT SHALL last exactly SETTLE cycles and then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; at its closing edge y_in is compared with ~(vec[1] | vec[0]).
REQ-019 On a SAMPLE mismatch, the FSM SHALL set fail_vec[vec] and increment err_cnt, saturating at all-ones (no wrap).
REQ-020 After SAMPLE with vec<3, the FSM SHALL increment vec and return to WAIT with settle count=0; with vec=3, it SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with done=1, SHALL load pass = (fail_vec==0, including the final sample), and SHALL then return to IDLE.
REQ-022 Run timing: with the start edge at cycle 0, busy SHALL be high for cycles 1..4*(SETTLE+1) and done SHALL be high in cycle 4*(SETTLE+1)+1; for SETTLE=2, busy is high in cycles 1..12 and done in cycle 13.
REQ-023 start SHALL be ignored in WAIT, SAMPLE and DONE; no queuing.
REQ-024 abort=1 in WAIT or SAMPLE SHALL go to IDLE at the next edge with no done pulse, pass=0, and err_cnt/fail_vec holding their partial values.
REQ-025 abort SHALL be ignored in IDLE and DONE.
REQ-026 If abort and start are both high in IDLE, start SHALL win.
REQ-027 pass, err_cnt and fail_vec SHALL hold their values after DONE until the next accepted start.
REQ-028 busy and done SHALL never both be high in the same cycle.

Reset
REQ-029 While rst_n=0, outputs SHALL immediately (asynchronously) be: state=IDLE, vec=0, settle count=0, a_out=b_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
REQ-030 Reset asserted mid-run SHALL discard the run; no done pulse is produced.
REQ-031 The first start after rst_n deasserts SHALL be accepted at the first clock edge.

Verification
REQ-032 Correct NOR model on y_in, SETTLE=2, start pulse -> a/b sequence 00,01,10,11 with 3 cycles each, done in cycle 13, pass=1, err_cnt=0, fail_vec=4'b0000.
REQ-033 y_in stuck at 0 -> fail_vec=4'b0001, err_cnt=1, pass=0; y_in stuck at 1 -> fail_vec=4'b1110, err_cnt=3, pass=0.
REQ-034 OR gate (y_in=a|b), ERR_W=3 -> fail_vec=4'b1111, err_cnt=4; same stimulus with ERR_W=2 -> err_cnt=3 (saturated).
REQ-035 start re-pulsed in cycle 5 and in the DONE cycle -> ignored, exactly one done pulse; abort during vec=2 -> IDLE next edge, no done, a_out=b_out=0, pass=0.
REQ-036 rst_n pulled low in cycle 7 (asynchronous, between edges) -> all outputs 0 immediately; after release, start gives a full normal run.

Source files
------------

// File: rtl/nor_tester_seq.sv
// Exhaustive tester for a 2-input NOR gate: drives all four {a,b} vectors,
// samples y_in after a settle delay and records per-vector mismatches.
module nor_tester_seq #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_vec, w_vec_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_a, r_b, w_a_nxt, w_b_nxt;
  logic             r_pass, w_pass_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic [3:0]       r_fail, w_fail_nxt;
  logic             w_mismatch;
  logic             w_drive_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;
    w_mismatch  = (y_in != ~(r_vec[1] | r_vec[0]));

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StWait;
          w_vec_nxt   = 2'd0;
          w_cnt_nxt   = 8'd0;
          w_err_nxt   = '0;
          w_fail_nxt  = 4'b0000;
          w_pass_nxt  = 1'b0;
        end
      end
      StWait: begin
        if (abort) begin
          w_state_nxt = StIdle;
          w_pass_nxt  = 1'b0;
        end else if (r_cnt == SettleLast) begin
          w_state_nxt = StSample;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StSample: begin
        if (abort) begin
          // Aborted sample is not recorded; partial results stay visible.
          w_state_nxt = StIdle;
          w_pass_nxt  = 1'b0;
        end else begin
          if (w_mismatch) begin
            w_fail_nxt[r_vec] = 1'b1;
            if (r_err != '1) w_err_nxt = r_err + ERR_W'(1);
          end
          if (r_vec == 2'd3) begin
            w_state_nxt = StDone;
            w_pass_nxt  = (w_fail_nxt == 4'b0000);
          end else begin
            w_state_nxt = StWait;
            w_vec_nxt   = r_vec + 2'd1;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_drive_nxt = (w_state_nxt == StWait) || (w_state_nxt == StSample);
    w_a_nxt     = w_drive_nxt & w_vec_nxt[1];
    w_b_nxt     = w_drive_nxt & w_vec_nxt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_vec   <= 2'd0;
      r_cnt   <= 8'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign busy     = (r_state == StWait) || (r_state == StSample);
  assign done     = (r_state == StDone);
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fail;

endmodule

// File: tb/tb_nor_tester_seq.sv
// Directed bench for nor_tester_seq: gate models on y_in, run timing, abort and reset.
module tb_nor_tester_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       y1, y2;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fail1;
  logic       a2, b2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] fail2;
  int         mode;
  int         n_checks = 0;
  int         n_errs   = 0;

  always #5 clk = ~clk;

  nor_tester_seq #(.SETTLE(2), .ERR_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fail1)
  );

  nor_tester_seq #(.SETTLE(2), .ERR_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_vec(fail2)
  );

  // 0: correct NOR, 1: stuck-at-0, 2: stuck-at-1, 3: OR gate
  always_comb begin
    case (mode)
      1:       begin y1 = 1'b0;     y2 = 1'b0;     end
      2:       begin y1 = 1'b1;     y2 = 1'b1;     end
      3:       begin y1 = a1 | b1;  y2 = a2 | b2;  end
      default: begin y1 = ~(a1 | b1); y2 = ~(a2 | b2); end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  task automatic run(input int m, input bit with_abort, input bit repulse,
                     input logic [3:0] exp_fail, input int exp_err1, input int exp_err2,
                     input logic exp_pass);
    int v;
    mode  = m;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      v = (k <= 12) ? (k - 1) / 3 : 0;
      chk($sformatf("busy_c%0d", k), 32'(busy1), 32'(k <= 12));
      chk($sformatf("done_c%0d", k), 32'(done1), 32'(k == 13));
      chk($sformatf("a_c%0d", k), 32'(a1), 32'((v >> 1) & 1));
      chk($sformatf("b_c%0d", k), 32'(b1), 32'(v & 1));
      if (k == 1) begin
        chk("pass_cleared", 32'(pass1), 32'd0);
        chk("err_cleared", 32'(err1), 32'd0);
        chk("fail_cleared", 32'(fail1), 32'd0);
      end
      if (k == 13 || k == 16) begin
        chk($sformatf("fail_c%0d", k), 32'(fail1), 32'(exp_fail));
        chk($sformatf("err_c%0d", k), 32'(err1), 32'(exp_err1));
        chk($sformatf("err_w2_c%0d", k), 32'(err2), 32'(exp_err2));
        chk($sformatf("pass_c%0d", k), 32'(pass1), 32'(exp_pass));
        chk($sformatf("done_w2_c%0d", k), 32'(done2), 32'(k == 13));
      end
      start = repulse && (k == 5 || k == 13);
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    #2;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_fail", 32'(fail1), 32'd0);
    chk("rst_ab", 32'({a1, b1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort held with start in idle: start must win. Correct NOR -> pass.
    run(0, 1'b1, 1'b0, 4'b0000, 0, 0, 1'b1);
    run(1, 1'b0, 1'b0, 4'b0001, 1, 1, 1'b0);
    run(2, 1'b0, 1'b0, 4'b1110, 3, 3, 1'b0);
    run(3, 1'b0, 1'b0, 4'b1111, 4, 3, 1'b0);
    run(0, 1'b0, 1'b1, 4'b0000, 0, 0, 1'b1);

    // Abort during vec=2 (cycles 7..9) with stuck-at-0 gate.
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 7) chk("abort_pre_a", 32'(a1), 32'd1);
      if (k >= 8) begin
        chk($sformatf("abort_busy_c%0d", k), 32'(busy1), 32'd0);
        chk($sformatf("abort_done_c%0d", k), 32'(done1), 32'd0);
      end
      if (k == 8) begin
        chk("abort_ab", 32'({a1, b1}), 32'd0);
        chk("abort_pass", 32'(pass1), 32'd0);
        chk("abort_err", 32'(err1), 32'd1);
        chk("abort_fail", 32'(fail1), 32'b0001);
      end
      abort = (k == 7);
    end
    abort = 1'b0;

    // Asynchronous reset in cycle 7 of a stuck-at-1 run.
    mode  = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_err", 32'(err1), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    chk("midrst_ab", 32'({a1, b1}), 32'd0);
    chk("midrst_err", 32'(err1), 32'd0);
    chk("midrst_fail", 32'(fail1), 32'd0);
    chk("midrst_pass", 32'(pass1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
